// File: rtl/looper_mult_pkg.sv
// Shared types and constants for the multiplier issue controller.
package looper_mult_pkg;

  localparam int unsigned TAG_W    = 6;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned QDEPTH   = 4;
  localparam int unsigned MULT_LAT = 9;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // One queued multiply: operands plus destination tag.
  typedef struct packed {
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [TAG_W-1:0]  tag;
  } mult_op_t;

endpackage

// File: rtl/mult_issue_ctrl_if.sv
// Bundle of the issue-queue, multiplier and writeback handshakes.
//  master : the issue controller (drives iq_ready, mult_*, wb_*, status)
//  slave  : the surrounding pipeline and multiplier
interface mult_issue_ctrl_if;
  import looper_mult_pkg::*;

  logic              iq_valid;
  logic              iq_ready;
  logic [DATA_W-1:0] iq_op1;
  logic [DATA_W-1:0] iq_op2;
  logic [TAG_W-1:0]  iq_tag;
  logic              flush;
  logic              mult_en;
  logic [DATA_W-1:0] mult_op1;
  logic [DATA_W-1:0] mult_op2;
  logic [DATA_W-1:0] mult_out;
  logic              mult_valid_wb;
  logic              wb_valid;
  logic              wb_ready;
  logic [DATA_W-1:0] wb_data;
  logic [TAG_W-1:0]  wb_tag;
  logic              busy;
  logic              err_timeout;

  modport master (
    input  iq_valid, iq_op1, iq_op2, iq_tag, flush, mult_out, mult_valid_wb, wb_ready,
    output iq_ready, mult_en, mult_op1, mult_op2, wb_valid, wb_data, wb_tag, busy, err_timeout
  );

  modport slave (
    output iq_valid, iq_op1, iq_op2, iq_tag, flush, mult_out, mult_valid_wb, wb_ready,
    input  iq_ready, mult_en, mult_op1, mult_op2, wb_valid, wb_data, wb_tag, busy, err_timeout
  );

endinterface

// File: rtl/mult_issue_fifo.sv
// Pending-op FIFO with show-ahead head.
//  clr   : synchronous clear, overrides push/pop in the same cycle
//  push  : write din (ignored when full)
//  pop   : drop the head (ignored when empty)
//  head  : current head entry, valid whenever empty=0
//  full / empty : occupancy flags
module mult_issue_fifo
  import looper_mult_pkg::*;
#(
  parameter int unsigned DEPTH = QDEPTH
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     clr,
  input  logic     push,
  input  mult_op_t din,
  input  logic     pop,
  output mult_op_t head,
  output logic     full,
  output logic     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  mult_op_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full & ~clr;
  assign pop_ok  = pop & ~empty & ~clr;
  assign head    = mem[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mult_issue_ctrl.sv
// Issue controller for the radix-4 Booth multiplier.
// Queues tagged ops, launches one at a time with a single-cycle mult_en,
// and returns each result with its tag on a valid/ready writeback port.
//  clk, rst_n : clock, asynchronous active-low reset
//  bus        : issue queue in, multiplier start/result, writeback out,
//               busy and sticky err_timeout status
module mult_issue_ctrl
  import looper_mult_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  mult_issue_ctrl_if.master  bus
);

  localparam int unsigned WDOG_MAX = MULT_LAT + 2;
  localparam int unsigned WDOG_W   = $clog2(WDOG_MAX + 1);

  state_e            state_q, state_d;
  logic              kill_q, kill_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [TAG_W-1:0]  inflight_tag_q, inflight_tag_d;
  logic              wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [TAG_W-1:0]  wb_tag_q, wb_tag_d;
  logic              err_q, err_d;

  logic              fifo_full;
  logic              fifo_empty;
  logic              push_c;
  logic              pop_c;
  logic              mult_en_c;
  mult_op_t          push_op;
  mult_op_t          head_op;

  assign push_c  = bus.iq_valid & ~fifo_full;
  assign push_op = '{op1: bus.iq_op1, op2: bus.iq_op2, tag: bus.iq_tag};

  mult_issue_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.flush),
    .push  (push_c),
    .din   (push_op),
    .pop   (pop_c),
    .head  (head_op),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      kill_q         <= 1'b0;
      wdog_q         <= '0;
      inflight_tag_q <= '0;
      wb_valid_q     <= 1'b0;
      wb_data_q      <= '0;
      wb_tag_q       <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      kill_q         <= kill_d;
      wdog_q         <= wdog_d;
      inflight_tag_q <= inflight_tag_d;
      wb_valid_q     <= wb_valid_d;
      wb_data_q      <= wb_data_d;
      wb_tag_q       <= wb_tag_d;
      err_q          <= err_d;
    end
  end

  // Next-state, issue and result-buffer logic.
  always_comb begin
    state_d        = state_q;
    kill_d         = kill_q;
    wdog_d         = wdog_q;
    inflight_tag_d = inflight_tag_q;
    wb_valid_d     = wb_valid_q;
    wb_data_d      = wb_data_q;
    wb_tag_d       = wb_tag_q;
    err_d          = err_q;
    mult_en_c      = 1'b0;
    pop_c          = 1'b0;

    if (wb_valid_q && bus.wb_ready) wb_valid_d = 1'b0;
    if (bus.flush)                  wb_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        // Only issue if the result buffer will be free when this op returns.
        if (!fifo_empty && !bus.flush && (!wb_valid_q || bus.wb_ready)) begin
          mult_en_c      = 1'b1;
          pop_c          = 1'b1;
          inflight_tag_d = head_op.tag;
          wdog_d         = '0;
          state_d        = BUSY;
        end
      end
      BUSY: begin
        if (wdog_q != WDOG_W'(WDOG_MAX)) wdog_d = wdog_q + WDOG_W'(1);
        if (bus.mult_valid_wb) begin
          state_d = IDLE;
          if (!kill_q && !bus.flush) begin
            wb_valid_d = 1'b1;
            wb_data_d  = bus.mult_out;
            wb_tag_d   = inflight_tag_q;
          end else begin
            kill_d = 1'b0;
          end
        end else begin
          if (bus.flush) kill_d = 1'b1;
          // wdog holds k-1 in BUSY cycle k, so the flag rises in cycle MULT_LAT+2.
          if (wdog_q == WDOG_W'(MULT_LAT)) err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.iq_ready    = ~fifo_full;
  assign bus.mult_en     = mult_en_c;
  assign bus.mult_op1    = head_op.op1;
  assign bus.mult_op2    = head_op.op2;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_tag      = wb_tag_q;
  assign bus.err_timeout = err_q;
  assign bus.busy        = (state_q == BUSY) | ~fifo_empty | wb_valid_q;

endmodule
